word_demux_collector: RTL and testbench
=======================================

// Module: word_demux_collector
// PURPOSE
//  Receive-side counterpart of the 8:1 word sequencer: accepts one WIDTH-bit word per valid cycle
//  and steers it into one of eight slots addressed by an internal up/down pointer (UD selects direction).
//  Slots are assembled in a working buffer and published atomically to outputs O0..O7 once 8 words are
//  accepted; FRAME_DONE flags each completed frame. Sits at the sink of the serial word link in TOP.
// PARAMETERS
//  WIDTH  8  bit width of DATA_IN and of each output slot O0..O7
// PORTS
//  CLOCK      in   1      single clock; all state updates on rising edge
//  CLR        in   1      synchronous, active-high reset
//  UD         in   1      pointer direction for accepted word: 1 = up (+1), 0 = down (-1), mod 8
//  SYNC       in   1      frame restart: discard partial frame, pointer and count to 0
//  IN_VALID   in   1      DATA_IN carries a word this cycle
//  DATA_IN    in   WIDTH  incoming word
//  O0..O7     out  WIDTH  published slots 0..7 (eight separate ports)
//  IDX        out  3      current write pointer (slot the next accepted word goes to)
//  FRAME_DONE out  1      one-cycle pulse: publish happened on the previous edge
//  FRAME_VLD  out  1      high once at least one frame has been published since reset
// BEHAVIOUR
//  - Reset (CLR=1 at edge): working buffer, O0..O7 = 0; IDX = 0; word count = 0; FRAME_DONE = 0;
//    FRAME_VLD = 0; FSM -> EMPTY. CLR overrides SYNC and IN_VALID; partial frame discarded.
//  - Accept: IN_VALID=1 at edge -> buf[IDX] <= DATA_IN; IDX <= IDX+1 (UD=1) or IDX-1 (UD=0), wrap 7->0 / 0->7;
//    count <= count+1. UD sampled per accepted word; UD may change mid-frame (pointer follows it).
//  - IN_VALID=0: no state change except FRAME_DONE returning to 0.
//  - FSM: EMPTY (count=0) -accept-> FILLING; FILLING -accept, count 1..6-> FILLING;
//    FILLING -8th accept-> PUBLISH action same edge -> EMPTY. No stall: one word per cycle sustained.
//  - Publish: on edge accepting 8th word, O[k] <= buf[k] for k!=IDX, O[IDX] <= DATA_IN (word merged in);
//    FRAME_DONE = 1 for exactly the next cycle; FRAME_VLD <= 1 (sticky until CLR); count <= 0.
//    IDX is NOT reset by publish: next frame starts where the pointer landed (pure up => back at 0).
//  - Latency: 8th word visible on O* one edge after it is presented; O* stable between publishes.
//  - Slots not written during a frame (possible if UD changes, revisiting slots) keep prior buf value;
//    a revisited slot holds the latest word written to it.
//  - SYNC=1 at edge: count <= 0, FSM -> EMPTY, buf cleared to 0; O0..O7 and FRAME_VLD untouched.
//    SYNC & IN_VALID same edge: SYNC wins for pointer; DATA_IN written to slot 0, IDX <= 1 (UD=1)
//    or 7 (UD=0), count <= 1 (word is first of new frame).
//  - Back-to-back frames: FRAME_DONE may be high while next frame's first word is accepted.
//  - Arithmetic: pointer is 3-bit modulo; count 0..7 (4-bit internal ok); no width extension of data.
// TESTING
//  1. CLR=1 two cycles -> O0..O7=00, IDX=0, FRAME_DONE=0, FRAME_VLD=0.
//  2. UD=1, IN_VALID=1, words 11,FF,AB,CC,99,88,E7,D0 -> next cycle O0..O7 = 11,FF,AB,CC,99,88,E7,D0;
//     FRAME_DONE one-cycle pulse; FRAME_VLD=1; IDX=0.
//  3. UD=0 from IDX=0, same 8 words -> O0=11,O7=FF,O6=AB,O5=CC,O4=99,O3=88,O2=E7,O1=D0; IDX=0.
//  4. UD=1, send 11,FF,AB then SYNC=1 with IN_VALID=1, DATA_IN=5A, then 7 more words 01..07 ->
//     O0..O7 = 5A,01,02,03,04,05,06,07; no FRAME_DONE before the 8th post-SYNC word.
//  5. IN_VALID gaps: 8 words spread over 20 cycles -> publish only on 8th accept; O* unchanged earlier.
//  6. CLR asserted after 5 words of a frame -> all outputs 0, next 8 words form a fresh frame from slot 0.

Source files
------------

// File: rtl/word_demux_collector.sv
// Word demux collector: steers serial words into eight slots via an up/down
// pointer and publishes the assembled frame atomically once 8 words arrive.
module word_demux_collector #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK,
  input  logic             CLR,
  input  logic             UD,
  input  logic             SYNC,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] O0,
  output logic [WIDTH-1:0] O1,
  output logic [WIDTH-1:0] O2,
  output logic [WIDTH-1:0] O3,
  output logic [WIDTH-1:0] O4,
  output logic [WIDTH-1:0] O5,
  output logic [WIDTH-1:0] O6,
  output logic [WIDTH-1:0] O7,
  output logic [2:0]       IDX,
  output logic             FRAME_DONE,
  output logic             FRAME_VLD
);

  typedef enum logic [0:0] {
    EMPTY,
    FILLING
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q [8];
  logic [WIDTH-1:0] buf_d [8];
  logic [WIDTH-1:0] out_q [8];
  logic [WIDTH-1:0] out_d [8];
  logic             done_q, done_d;
  logic             vld_q, vld_d;

  logic [2:0]       wr_idx;
  logic [2:0]       step;
  logic             last_word;

  // SYNC restarts the frame, so a word arriving with it lands in slot 0
  assign wr_idx    = SYNC ? 3'd0 : idx_q;
  assign step      = UD ? 3'd1 : 3'd7;
  assign last_word = !SYNC && (state_q == FILLING) && (cnt_q == 4'd7);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    vld_d   = vld_q;
    for (int k = 0; k < 8; k++) begin
      buf_d[k] = buf_q[k];
      out_d[k] = out_q[k];
    end

    if (SYNC) begin
      state_d = EMPTY;
      idx_d   = 3'd0;
      cnt_d   = 4'd0;
      for (int k = 0; k < 8; k++) begin
        buf_d[k] = '0;
      end
    end

    if (IN_VALID) begin
      buf_d[wr_idx] = DATA_IN;
      idx_d         = wr_idx + step;
      unique case (1'b1)
        last_word: begin
          for (int k = 0; k < 8; k++) begin
            out_d[k] = buf_d[k];
          end
          done_d  = 1'b1;
          vld_d   = 1'b1;
          cnt_d   = 4'd0;
          state_d = EMPTY;
        end
        default: begin
          cnt_d   = (SYNC ? 4'd0 : cnt_q) + 4'd1;
          state_d = FILLING;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (CLR) begin
      state_q <= EMPTY;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        buf_q[k] <= '0;
        out_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      for (int k = 0; k < 8; k++) begin
        buf_q[k] <= buf_d[k];
        out_q[k] <= out_d[k];
      end
    end
  end

  assign O0         = out_q[0];
  assign O1         = out_q[1];
  assign O2         = out_q[2];
  assign O3         = out_q[3];
  assign O4         = out_q[4];
  assign O5         = out_q[5];
  assign O6         = out_q[6];
  assign O7         = out_q[7];
  assign IDX        = idx_q;
  assign FRAME_DONE = done_q;
  assign FRAME_VLD  = vld_q;

endmodule

// File: tb/tb_word_demux_collector.sv
// Self-checking bench for word_demux_collector: directed frames plus
// randomized traffic against a frame-level reference model.
module tb_word_demux_collector;

  logic       clk;
  logic       clr, ud, sync, vin;
  logic [7:0] din;
  logic [7:0] o [8];
  logic [2:0] idx;
  logic       fdone, fvld;

  int checks;
  int failures;

  // reference model state
  logic [7:0] m_buf [8];
  logic [7:0] m_out [8];
  logic [2:0] m_ptr;
  int         m_cnt;
  logic       m_done, m_vld;

  word_demux_collector #(.WIDTH(8)) dut (
    .CLOCK(clk), .CLR(clr), .UD(ud), .SYNC(sync),
    .IN_VALID(vin), .DATA_IN(din),
    .O0(o[0]), .O1(o[1]), .O2(o[2]), .O3(o[3]),
    .O4(o[4]), .O5(o[5]), .O6(o[6]), .O7(o[7]),
    .IDX(idx), .FRAME_DONE(fdone), .FRAME_VLD(fvld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic c, input logic u, input logic s,
                            input logic v, input logic [7:0] d);
    if (c) begin
      for (int k = 0; k < 8; k++) begin
        m_buf[k] = 8'h00;
        m_out[k] = 8'h00;
      end
      m_ptr = 3'd0; m_cnt = 0; m_done = 1'b0; m_vld = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (s) begin
      for (int k = 0; k < 8; k++) m_buf[k] = 8'h00;
      m_ptr = 3'd0; m_cnt = 0;
    end
    if (v) begin
      m_buf[m_ptr] = d;
      m_ptr = u ? m_ptr + 3'd1 : m_ptr - 3'd1;
      m_cnt = m_cnt + 1;
      if (m_cnt == 8) begin
        for (int k = 0; k < 8; k++) m_out[k] = m_buf[k];
        m_done = 1'b1; m_vld = 1'b1; m_cnt = 0;
      end
    end
  endtask

  task automatic check_all(input string ph);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_O%0d", ph, k), {24'd0, o[k]}, {24'd0, m_out[k]});
    chk({ph, "_IDX"}, {29'd0, idx}, {29'd0, m_ptr});
    chk({ph, "_DONE"}, {31'd0, fdone}, {31'd0, m_done});
    chk({ph, "_VLD"}, {31'd0, fvld}, {31'd0, m_vld});
  endtask

  task automatic cyc(input string ph, input logic c, input logic u,
                     input logic s, input logic v, input logic [7:0] d);
    clr = c; ud = u; sync = s; vin = v; din = d;
    @(posedge clk);
    model_step(c, u, s, v, d);
    #1;
    check_all(ph);
  endtask

  logic [7:0] words [8];

  initial begin
    checks = 0; failures = 0;
    clr = 1'b1; ud = 1'b1; sync = 1'b0; vin = 1'b0; din = 8'h00;
    words[0] = 8'h11; words[1] = 8'hFF; words[2] = 8'hAB; words[3] = 8'hCC;
    words[4] = 8'h99; words[5] = 8'h88; words[6] = 8'hE7; words[7] = 8'hD0;

    // 1: reset
    cyc("rst", 1, 1, 0, 0, 8'h00);
    cyc("rst", 1, 1, 0, 0, 8'h00);
    chk("rst_O0_const", {24'd0, o[0]}, 32'h0);

    // 2: up frame
    for (int i = 0; i < 8; i++) cyc("up", 0, 1, 0, 1, words[i]);
    chk("up_O3_const", {24'd0, o[3]}, 32'hCC);
    chk("up_O7_const", {24'd0, o[7]}, 32'hD0);
    chk("up_pulse", {31'd0, fdone}, 32'h1);
    cyc("up_idle", 0, 1, 0, 0, 8'h00);
    chk("up_pulse_end", {31'd0, fdone}, 32'h0);

    // 3: down frame from slot 0
    for (int i = 0; i < 8; i++) cyc("dn", 0, 0, 0, 1, words[i]);
    chk("dn_O7_const", {24'd0, o[7]}, 32'hFF);
    chk("dn_O1_const", {24'd0, o[1]}, 32'hD0);
    chk("dn_IDX_const", {29'd0, idx}, 32'h0);

    // 4: partial frame then SYNC with word
    for (int i = 0; i < 3; i++) cyc("sy_pre", 0, 1, 0, 1, words[i]);
    cyc("sy", 0, 1, 1, 1, 8'h5A);
    for (int i = 1; i <= 7; i++) cyc("sy_post", 0, 1, 0, 1, 8'(i));
    chk("sy_O0_const", {24'd0, o[0]}, 32'h5A);
    chk("sy_O7_const", {24'd0, o[7]}, 32'h07);

    // 5: gapped frame over 20 cycles
    for (int i = 0, n = 0; i < 20; i++) begin
      if ((i % 5 == 0 || i % 5 == 2 || i % 5 == 4) && n < 8) begin
        cyc("gap", 0, 1, 0, 1, 8'(8'h40 + n));
        n++;
      end else begin
        cyc("gap", 0, 1, 0, 0, 8'hEE);
      end
    end

    // 6: CLR mid-frame then fresh frame
    for (int i = 0; i < 5; i++) cyc("cl_pre", 0, 1, 0, 1, words[i]);
    cyc("cl", 1, 1, 0, 1, 8'h77);
    for (int i = 0; i < 8; i++) cyc("cl_post", 0, 1, 0, 1, words[7 - i]);
    chk("cl_O0_const", {24'd0, o[0]}, 32'hD0);

    // randomized traffic, including direction changes mid-frame
    for (int i = 0; i < 400; i++) begin
      cyc("rnd", ($urandom_range(0, 99) == 0), 1'($urandom),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
          8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
